watch_display: RTL and testbench
================================

// Module: watch_display
// PURPOSE
//  Reader/consumer side of the watch time outputs. Samples seconds/minutes/hours,
//  converts each to two BCD digits and drives a 6-digit multiplexed common-anode
//  7-segment display (HH.MM.SS). Sits between the watch counter and board pins.
//  Time is snapshotted once per scan frame so a displayed frame never mixes two times.
// PARAMETERS
//  SCAN_DIV  1000  Clk cycles per digit slot (>= GUARD+2)
//  GUARD     4     cycles at the start of each slot with all anodes off (anti-ghost)
//  BLANK_HTZ 1     1: blank hours-tens digit when it is 0
// PORTS
//  Clk       in   1  system clock, all logic on posedge
//  reset_n   in   1  asynchronous, active-low reset
//  seconds   in   6  binary seconds, legal 0..59, synchronous to Clk
//  minutes   in   6  binary minutes, legal 0..59
//  hours     in   5  binary hours, legal 0..23
//  seg_n     out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp_n      out  1  decimal point, active-low
//  an_n      out  6  digit enables, active-low; an_n[0]=sec ones .. an_n[5]=hr tens
//  frame     out  1  1-cycle pulse when a new snapshot is taken
// BEHAVIOUR
//  - Reset (async assert, sync release): div=0, idx=0, snapshot=00:00:00,
//    seg_n=7'h7F, dp_n=1, an_n=6'h3F, frame=0. All outputs registered.
//  - div counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and idx advances 0..5, 5->0.
//  - Snapshot: on the edge where idx wraps 5->0, latch seconds/minutes/hours and
//    pulse frame for that cycle. Also on the first cycle after reset release.
//    Input changes mid-frame are ignored until the next wrap.
//  - Digit map idx: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hr ones, 5 hr tens.
//  - BCD: tens = v/10, ones = v%10 on 6-bit/5-bit values; combinational from snapshot.
//  - Out-of-range snapshot field (sec/min>59, hr>23): both digits of that field show
//    dash (seg_n=7'b0111111, g only); other fields unaffected.
//  - BLANK_HTZ=1 and hr tens==0: slot 5 keeps an_n all-high for the whole slot.
//  - Slot timing: for div<GUARD, an_n=6'h3F; for div>=GUARD, an_n has only bit idx low.
//    seg_n/dp_n for the slot are valid from div==0 (one cycle after idx changes,
//    since outputs are registered) and stable for the whole slot.
//  - dp_n=0 on idx 2 and idx 4 when snapshot seconds[0]==0 (separator blinks at 0.5 Hz
//    of displayed seconds); otherwise 1.
//  - Segment code 0..9 a..g active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//  - reset_n asserted mid-slot: outputs go to reset values immediately (async).
// STRUCTURE
//  - Shared package watch_pkg: SEG_* digit constants, SEG_DASH, SEG_OFF, IDX_* slot
//    localparams, SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
//  - One sub-module seg7_encode (4-bit BCD + dash flag -> 7-bit active-low pattern),
//    instantiated once on the muxed digit.
// TESTING
//  1. Reset: hold reset_n=0 -> seg_n=7F, an_n=3F, dp_n=1; release -> frame pulses once.
//  2. SCAN_DIV=8,GUARD=2, input 12:34:56 -> slots show 6,5,4,3,2,1 (seg 02,12,19,30,24,79);
//     an_n low only for div>=2; dp_n=0 on slots 2,4.
//  3. Change input 12:34:56 -> 23:59:59 at idx=3 -> rest of frame still 12:34:56;
//     next frame shows 23:59:59 with dp_n=1.
//  4. hours=5, BLANK_HTZ=1 -> slot 5 an_n stays 3F all slot; BLANK_HTZ=0 -> seg 40 shown.
//  5. minutes=60 -> slots 2,3 show 3F (dash); seconds/hours digits correct.
//  6. Assert reset_n at idx=4,div=5 -> outputs reset same cycle; restart at idx 0.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared constants and helpers for the watch display path.
//   SEG_*    : active-low {g,f,e,d,c,b,a} patterns for digits, dash and blank
//   IDX_*    : digit slot numbers, slot 0 = seconds ones .. slot 5 = hours tens
//   *_MAX    : largest legal value of each time field
//   time_t   : one snapshot of the time inputs
//   to_bcd   : binary 0..63 to {tens, ones} BCD
package watch_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [2:0] IDX_SEC_ONES = 3'd0;
  localparam logic [2:0] IDX_SEC_TENS = 3'd1;
  localparam logic [2:0] IDX_MIN_ONES = 3'd2;
  localparam logic [2:0] IDX_MIN_TENS = 3'd3;
  localparam logic [2:0] IDX_HR_ONES  = 3'd4;
  localparam logic [2:0] IDX_HR_TENS  = 3'd5;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
  } time_t;

  // Binary to two BCD digits; callers zero-extend narrower fields.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] tens_v;
    logic [5:0] ones_v;
    tens_v = v / 6'd10;
    ones_v = v % 6'd10;
    return {tens_v[3:0], ones_v[3:0]};
  endfunction

endpackage

// File: rtl/watch_display_if.sv
// Time-in / display-out bundle between the watch counter and the display driver.
//   seconds/minutes/hours : binary time from the counter
//   seg_n/dp_n/an_n/frame : display pins and snapshot strobe
// master = time source / pin observer, slave = watch_display.
interface watch_display_if;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;
  logic       frame;

  modport master (output seconds, minutes, hours, input seg_n, dp_n, an_n, frame);
  modport slave  (input seconds, minutes, hours, output seg_n, dp_n, an_n, frame);
endinterface

// File: rtl/seg7_encode.sv
// One BCD digit (or a dash) to an active-low 7-segment pattern {g,f,e,d,c,b,a}.
//   bcd   in  4  digit 0..9 (10..15 show blank)
//   dash  in  1  force the dash pattern
//   seg_n out 7  active-low segments
module seg7_encode
  import watch_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dash,
  output logic [6:0] seg_n
);

  // Pattern lookup; dash has priority over the digit value.
  always_comb begin
    seg_n = SEG_OFF;
    if (dash) begin
      seg_n = SEG_DASH;
    end else begin
      case (bcd)
        4'd0:    seg_n = SEG_0;
        4'd1:    seg_n = SEG_1;
        4'd2:    seg_n = SEG_2;
        4'd3:    seg_n = SEG_3;
        4'd4:    seg_n = SEG_4;
        4'd5:    seg_n = SEG_5;
        4'd6:    seg_n = SEG_6;
        4'd7:    seg_n = SEG_7;
        4'd8:    seg_n = SEG_8;
        4'd9:    seg_n = SEG_9;
        default: seg_n = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/watch_display.sv
// Six-digit multiplexed common-anode display driver for HH.MM.SS.
//   Clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of watch_display_if (time in, seg_n/dp_n/an_n/frame out)
// The time is snapshotted once per scan frame (and on the first cycle after
// reset) so one frame never mixes two times. All outputs are computed from the
// next-state counters and snapshot and then registered, so the registered
// slot content lines up exactly with the registered div/idx.
module watch_display
  import watch_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int GUARD     = 4,
  parameter int BLANK_HTZ = 1
) (
  input  logic              Clk,
  input  logic              reset_n,
  watch_display_if.slave    bus
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_V  = DIV_W'(GUARD);

  logic [DIV_W-1:0] div_r, div_n_s;
  logic [2:0]       idx_r, idx_n_s;
  logic             first_r;
  time_t            snap_r, snap_n_s;
  logic             wrap_s;
  logic [6:0]       seg_r, seg_n_s;
  logic             dp_r, dp_n_s;
  logic [5:0]       an_r, an_n_s;
  logic             frame_r;
  logic [7:0]       sec_bcd_s, min_bcd_s, hr_bcd_s;
  logic             sec_bad_s, min_bad_s, hr_bad_s;
  logic [3:0]       digit_s;
  logic             dash_s;
  logic             blank_s;

  // Scan counters and snapshot selection for the coming cycle.
  always_comb begin
    div_n_s = div_r;
    idx_n_s = idx_r;
    wrap_s  = 1'b0;
    if (first_r) begin
      // First cycle out of reset: take a snapshot and start slot 0 afresh.
      div_n_s = '0;
      idx_n_s = IDX_SEC_ONES;
      wrap_s  = 1'b1;
    end else if (div_r == DIV_LAST) begin
      div_n_s = '0;
      if (idx_r == IDX_HR_TENS) begin
        idx_n_s = IDX_SEC_ONES;
        wrap_s  = 1'b1;
      end else begin
        idx_n_s = idx_r + 3'd1;
      end
    end else begin
      div_n_s = div_r + DIV_W'(1);
    end
    snap_n_s = wrap_s ? '{sec: bus.seconds, min: bus.minutes, hr: bus.hours} : snap_r;
  end

  // BCD conversion and range checks on the snapshot that will be displayed.
  always_comb begin
    sec_bcd_s = to_bcd(snap_n_s.sec);
    min_bcd_s = to_bcd(snap_n_s.min);
    hr_bcd_s  = to_bcd({1'b0, snap_n_s.hr});
    sec_bad_s = (snap_n_s.sec > SEC_MAX);
    min_bad_s = (snap_n_s.min > MIN_MAX);
    hr_bad_s  = (snap_n_s.hr > HR_MAX);
  end

  // Digit mux for the slot being entered.
  always_comb begin
    digit_s = 4'd0;
    dash_s  = 1'b0;
    case (idx_n_s)
      IDX_SEC_ONES: begin digit_s = sec_bcd_s[3:0]; dash_s = sec_bad_s; end
      IDX_SEC_TENS: begin digit_s = sec_bcd_s[7:4]; dash_s = sec_bad_s; end
      IDX_MIN_ONES: begin digit_s = min_bcd_s[3:0]; dash_s = min_bad_s; end
      IDX_MIN_TENS: begin digit_s = min_bcd_s[7:4]; dash_s = min_bad_s; end
      IDX_HR_ONES:  begin digit_s = hr_bcd_s[3:0];  dash_s = hr_bad_s;  end
      IDX_HR_TENS:  begin digit_s = hr_bcd_s[7:4];  dash_s = hr_bad_s;  end
      default:      begin digit_s = 4'd0;           dash_s = 1'b1;      end
    endcase
  end

  seg7_encode u_enc (
    .bcd   (digit_s),
    .dash  (dash_s),
    .seg_n (seg_n_s)
  );

  // Anode and separator decode; the guard window keeps every anode off.
  always_comb begin
    blank_s = (BLANK_HTZ != 0) && (idx_n_s == IDX_HR_TENS) && !hr_bad_s &&
              (hr_bcd_s[7:4] == 4'd0);
    if ((div_n_s < GUARD_V) || blank_s) begin
      an_n_s = 6'h3F;
    end else begin
      an_n_s = ~(6'b000001 << idx_n_s);
    end
    if (((idx_n_s == IDX_MIN_ONES) || (idx_n_s == IDX_HR_ONES)) && !snap_n_s.sec[0]) begin
      dp_n_s = 1'b0;
    end else begin
      dp_n_s = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r   <= '0;
      idx_r   <= IDX_SEC_ONES;
      first_r <= 1'b1;
      snap_r  <= '0;
      seg_r   <= SEG_OFF;
      dp_r    <= 1'b1;
      an_r    <= 6'h3F;
      frame_r <= 1'b0;
    end else begin
      div_r   <= div_n_s;
      idx_r   <= idx_n_s;
      first_r <= 1'b0;
      snap_r  <= snap_n_s;
      seg_r   <= seg_n_s;
      dp_r    <= dp_n_s;
      an_r    <= an_n_s;
      frame_r <= wrap_s;
    end
  end

  assign bus.seg_n = seg_r;
  assign bus.dp_n  = dp_r;
  assign bus.an_n  = an_r;
  assign bus.frame = frame_r;

endmodule

// File: tb/tb_watch_display.sv
// Directed bench: two instances with SCAN_DIV=8, GUARD=2; dut_a blanks a zero
// hours-tens digit, dut_b does not. Outputs are sampled on the falling edge.
module tb_watch_display;
  import watch_pkg::*;

  logic Clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  watch_display_if bus_a ();
  watch_display_if bus_b ();

  watch_display #(.SCAN_DIV(8), .GUARD(2), .BLANK_HTZ(1)) dut_a (
    .Clk(Clk), .reset_n(reset_n), .bus(bus_a.slave));
  watch_display #(.SCAN_DIV(8), .GUARD(2), .BLANK_HTZ(0)) dut_b (
    .Clk(Clk), .reset_n(reset_n), .bus(bus_b.slave));

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    bus_a.hours = h; bus_a.minutes = m; bus_a.seconds = s;
    bus_b.hours = h; bus_b.minutes = m; bus_b.seconds = s;
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  // One full frame starting at slot 0 / div 0. segs[k] is the pattern for slot k.
  // The next time is applied at slot 3 and must not show until the next frame.
  task automatic check_frame(input string name, input logic [5:0][6:0] segs,
                             input logic dp_on, input logic blank5,
                             input logic [4:0] nh, input logic [5:0] nm,
                             input logic [5:0] ns);
    logic [6:0] an_a_e, an_b_e, dp_e;
    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < 8; d++) begin
        if (k == 3 && d == 0) set_time(nh, nm, ns);
        an_b_e = (d < 2) ? 7'h3F : {1'b0, ~(6'b000001 << k)};
        an_a_e = (blank5 && k == 5) ? 7'h3F : an_b_e;
        dp_e   = (dp_on && (k == 2 || k == 4)) ? 7'd0 : 7'd1;
        check($sformatf("%s a an s%0d d%0d", name, k, d), {1'b0, bus_a.an_n}, an_a_e);
        check($sformatf("%s b an s%0d d%0d", name, k, d), {1'b0, bus_b.an_n}, an_b_e);
        check($sformatf("%s b seg s%0d d%0d", name, k, d), bus_b.seg_n, segs[k]);
        if (!(blank5 && k == 5))
          check($sformatf("%s a seg s%0d d%0d", name, k, d), bus_a.seg_n, segs[k]);
        check($sformatf("%s a dp s%0d d%0d", name, k, d), {6'd0, bus_a.dp_n}, dp_e);
        check($sformatf("%s a frame s%0d d%0d", name, k, d), {6'd0, bus_a.frame},
              (k == 0 && d == 0) ? 7'd1 : 7'd0);
        tick();
      end
    end
  endtask

  initial begin
    set_time(5'd12, 6'd34, 6'd56);
    // Reset held: all outputs at their idle values.
    repeat (3) tick();
    check("rst seg", bus_a.seg_n, 7'h7F);
    check("rst an", {1'b0, bus_a.an_n}, 7'h3F);
    check("rst dp", {6'd0, bus_a.dp_n}, 7'd1);
    check("rst frame", {6'd0, bus_a.frame}, 7'd0);
    reset_n = 1'b1;
    tick();

    // 12:34:56 -> digits 6,5,4,3,2,1; separator on (even seconds).
    check_frame("f1", {SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6}, 1'b1, 1'b0,
                5'd23, 6'd59, 6'd59);
    // 23:59:59 -> 9,5,9,5,3,2; odd seconds, separator off.
    check_frame("f2", {SEG_2, SEG_3, SEG_5, SEG_9, SEG_5, SEG_9}, 1'b0, 1'b0,
                5'd5, 6'd34, 6'd56);
    // 05:34:56 -> hours tens is zero: dut_a blanks slot 5, dut_b shows '0'.
    check_frame("f3", {SEG_0, SEG_5, SEG_3, SEG_4, SEG_5, SEG_6}, 1'b1, 1'b1,
                5'd12, 6'd60, 6'd56);
    // 12:60:56 -> minute digits dashed, others normal.
    check_frame("f4", {SEG_1, SEG_2, SEG_DASH, SEG_DASH, SEG_5, SEG_6}, 1'b1, 1'b0,
                5'd12, 6'd34, 6'd56);

    // Walk to slot 4, div 5 of the next frame and reset asynchronously there.
    repeat (4 * 8 + 5) tick();
    check("pre-rst an", {1'b0, bus_a.an_n}, 7'h2F);
    reset_n = 1'b0;
    #1;
    check("async seg", bus_a.seg_n, 7'h7F);
    check("async an", {1'b0, bus_a.an_n}, 7'h3F);
    check("async dp", {6'd0, bus_a.dp_n}, 7'd1);
    check("async frame", {6'd0, bus_a.frame}, 7'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("restart frame", {6'd0, bus_a.frame}, 7'd1);
    check("restart an", {1'b0, bus_a.an_n}, 7'h3F);
    check("restart seg", bus_a.seg_n, SEG_6);
    tick();
    check("restart frame low", {6'd0, bus_a.frame}, 7'd0);
    tick();
    check("restart an slot0", {1'b0, bus_a.an_n}, 7'h3E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
